// File: rtl/load_store_unit.sv
// Memory-access stage: one byte/halfword/word load or store per instruction over a
// valid/ready data-memory port, with lane steering, strobes, extension and alignment faults.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic [2:0]      LoadOrStoreTYPE,
    input  logic [XLEN-1:0] Address,
    input  logic [XLEN-1:0] StoreData,
    output logic            Stall,
    output logic [XLEN-1:0] LoadData,
    output logic            LoadValid,
    output logic            Fault,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [1:0]      debug_state
);
    // Handshake: a request transfers on a cycle where mem_req_valid & mem_req_ready are both
    // high; valid never drops and request fields never change until that cycle. mem_rsp_valid
    // is a single-cycle response (read data or write ack) and only counts in RESP.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    state_t            state, state_nxt;
    logic              start, legal, misaligned, access_fault;
    logic [3:0]        wstrb_d;
    logic [XLEN-1:0]   wdata_d, lane, load_ext;
    logic              we_q, fault_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    assign start = op_valid & (MemWrite | MemtoReg);

    // Decode of the incoming op; a store wins when both controls are set.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        wstrb_d    = 4'b0000;
        wdata_d    = StoreData;
        if (MemWrite) legal = (LoadOrStoreTYPE == 3'b000) || (LoadOrStoreTYPE == 3'b001) ||
                              (LoadOrStoreTYPE == 3'b010);
        else          legal = (LoadOrStoreTYPE == 3'b000) || (LoadOrStoreTYPE == 3'b001) ||
                              (LoadOrStoreTYPE == 3'b010) || (LoadOrStoreTYPE == 3'b100) ||
                              (LoadOrStoreTYPE == 3'b101);
        case (LoadOrStoreTYPE[1:0])
            2'b00: begin
                wdata_d = {4{StoreData[7:0]}};
                wstrb_d = 4'b0001 << Address[1:0];
            end
            2'b01: begin
                misaligned = Address[0];
                wdata_d    = {2{StoreData[15:0]}};
                wstrb_d    = 4'b0011 << Address[1:0];
            end
            default: begin
                misaligned = |Address[1:0];
                wstrb_d    = 4'b1111;
            end
        endcase
        if (!MemWrite) wstrb_d = 4'b0000;
        access_fault = ~legal | misaligned;
    end

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = access_fault ? DONE : REQ;
            REQ:  if (mem_req_ready) state_nxt = RESP;
            RESP: if (mem_rsp_valid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            LoadData  <= '0;
        end else begin
            if (state == IDLE && start) begin
                we_q      <= MemWrite;
                fault_q   <= access_fault;
                f3_q      <= LoadOrStoreTYPE;
                off_q     <= Address[1:0];
                mem_addr  <= {Address[XLEN-1:2], 2'b00};
                mem_wdata <= wdata_d;
                mem_wstrb <= wstrb_d;
            end
            if (state == RESP && mem_rsp_valid && !we_q) LoadData <= load_ext;
        end
    end

    // DONE holds Stall low so the pipeline advances while the finished op is still presented.
    always_comb begin
        Stall         = rst_n & (((state == IDLE) & start) | (state == REQ) | (state == RESP));
        mem_req_valid = (state == REQ);
        mem_we        = we_q;
        LoadValid     = (state == DONE) & ~we_q & ~fault_q;
        Fault         = (state == DONE) & fault_q;
        debug_state   = state;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit: a transaction-level model predicts
// every cycle's outputs, one compare process checks them, and directed cases pin the model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n, op_valid, MemWrite, MemtoReg;
    logic [2:0]  LoadOrStoreTYPE;
    logic [31:0] Address, StoreData;
    logic        Stall, LoadValid, Fault, mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] LoadData, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  debug_state;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .LoadOrStoreTYPE(LoadOrStoreTYPE), .Address(Address), .StoreData(StoreData),
        .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .Fault(Fault),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .debug_state(debug_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;
    int          lv_cnt = 0;
    logic [31:0] exp_q[$];
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req_valid = 1'b0, exp_lv = 1'b0, exp_fault = 1'b0;
    logic        chk_req = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_ld = 32'h0, exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access rules computed from size/offset arithmetic
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit op_fault(input logic we, input logic [2:0] f3, input logic [1:0] o);
        bit legal;
        int oi;
        oi = int'(o);
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || ((oi % acc_size(f3)) != 0);
    endfunction

    function automatic logic [3:0] f_strb(input logic we, input logic [2:0] f3, input logic [1:0] o);
        logic [3:0] s;
        int oi;
        s  = 4'h0;
        oi = int'(o);
        if (we) for (int i = 0; i < 4; i++) if (i >= oi && i < oi + acc_size(f3)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (acc_size(f3))
            1:       return {4{sd[7:0]}};
            2:       return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * int'(o));
        case (f3)
            3'd0:    return int'($signed(w[7:0]));
            3'd1:    return int'($signed(w[15:0]));
            3'd4:    return {24'h0, w[7:0]};
            3'd5:    return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Scoreboard / compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(Stall), 32'(exp_stall));
            check("req_valid", 32'(mem_req_valid), 32'(exp_req_valid));
            check("load_valid", 32'(LoadValid), 32'(exp_lv));
            check("fault", 32'(Fault), 32'(exp_fault));
            check("load_data", LoadData, exp_ld);
            if (chk_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (Stall) stall_cnt++;
            if (LoadValid) begin
                lv_cnt++;
                if (exp_q.size() == 0) check("load_q_size", 32'(exp_q.size()), 32'd1);
                else check("load_sb", LoadData, exp_q.pop_front());
            end
        end
    end

    // Driver tasks (entered and left #1 after a rising edge)
    task automatic idle_cycle();
        op_valid        = 1'($urandom_range(0, 1));
        MemWrite        = 1'b0;
        MemtoReg        = 1'b0;
        LoadOrStoreTYPE = 3'($urandom_range(0, 7));
        Address         = $urandom;
        mem_req_ready   = 1'($urandom_range(0, 1));
        mem_rsp_valid   = 1'($urandom_range(0, 1));
        mem_rdata       = $urandom;
        exp_stall = 1'b0; exp_req_valid = 1'b0; chk_req = 1'b0; exp_lv = 1'b0; exp_fault = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic we_in, input logic ld_in, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int r_dly, input int d_dly);
        logic we;
        bit   flt;
        we  = we_in;
        flt = op_fault(we, f3, addr[1:0]);
        op_valid = 1'b1; MemWrite = we_in; MemtoReg = ld_in; LoadOrStoreTYPE = f3;
        Address = addr; StoreData = sd;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
        exp_stall = 1'b1; exp_req_valid = 1'b0; chk_req = 1'b0; exp_lv = 1'b0; exp_fault = 1'b0;
        @(posedge clk); #1;
        if (!flt) begin
            exp_we    = we;
            exp_addr  = {addr[31:2], 2'b00};
            exp_wdata = f_wdata(f3, sd);
            exp_wstrb = f_strb(we, f3, addr[1:0]);
            for (int j = 0; j <= r_dly; j++) begin
                mem_req_ready = (j == r_dly);
                mem_rsp_valid = (j < r_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata     = $urandom;
                exp_req_valid = 1'b1; chk_req = 1'b1;
                @(posedge clk); #1;
            end
            exp_req_valid = 1'b0; chk_req = 1'b0; mem_req_ready = 1'b0;
            for (int j = 0; j <= d_dly; j++) begin
                mem_rsp_valid = (j == d_dly);
                mem_rdata     = (j == d_dly) ? rdata : $urandom;
                @(posedge clk); #1;
            end
        end
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
        exp_stall = 1'b0; exp_fault = flt; exp_lv = !flt && !we;
        if (exp_lv) begin
            exp_ld = f_load(f3, addr[1:0], rdata);
            exp_q.push_back(exp_ld);
        end
        @(posedge clk); #1;
        exp_lv = 1'b0; exp_fault = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        rst_n = 1'b0; op_valid = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; LoadOrStoreTYPE = 3'd2;
        Address = 32'h0; StoreData = 32'h0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_state", 32'(debug_state), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_load_data", LoadData, 32'h0);
        rst_n = 1'b1;
        idle_cycle();

        // LW aligned
        stall_cnt = 0;
        run_op(1'b0, 1'b1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        check("lw_data", LoadData, 32'hDEADBEEF);
        check("lw_addr", mem_addr, 32'h100);
        check("lw_wstrb", 32'(mem_wstrb), 32'h0);
        check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
        idle_cycle();
        run_op(1'b0, 1'b1, 3'd0, 32'h203, 32'h0, 32'h80123456, 0, 0);
        check("lb_data", LoadData, 32'hFFFFFF80);
        run_op(1'b0, 1'b1, 3'd4, 32'h203, 32'h0, 32'h80123456, 1, 0);
        check("lbu_data", LoadData, 32'h00000080);
        lv_cnt = 0;
        run_op(1'b1, 1'b0, 3'd1, 32'h302, 32'h1234ABCD, 32'h0, 0, 1);
        check("sh_addr", mem_addr, 32'h300);
        check("sh_wstrb", 32'(mem_wstrb), 32'hC);
        check("sh_wdata", mem_wdata, 32'hABCDABCD);
        check("sh_we", 32'(mem_we), 32'd1);
        check("sh_no_load_valid", 32'(lv_cnt), 32'd0);
        check("sh_load_data_kept", LoadData, 32'h00000080);
        idle_cycle();

        // Faults
        stall_cnt = 0;
        run_op(1'b0, 1'b1, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0);
        check("lw_mis_stall_cycles", 32'(stall_cnt), 32'd1);
        stall_cnt = 0;
        run_op(1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
        check("ld_f3_011_stall_cycles", 32'(stall_cnt), 32'd1);
        idle_cycle();

        // Backpressure
        stall_cnt = 0; lv_cnt = 0;
        run_op(1'b0, 1'b1, 3'd5, 32'h442, 32'h0, 32'hBEEF0000, 3, 1);
        check("bp_stall_cycles", 32'(stall_cnt), 32'd7);
        check("bp_completions", 32'(lv_cnt), 32'd1);
        check("bp_data", LoadData, 32'h0000BEEF);
        idle_cycle();

        // Reset while waiting for the response
        lv_cnt = 0;
        op_valid = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; LoadOrStoreTYPE = 3'd2; Address = 32'h40;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b1; exp_req_valid = 1'b1; chk_req = 1'b1;
        exp_we = 1'b0; exp_addr = 32'h40; exp_wstrb = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b0; op_valid = 1'b0; mem_req_ready = 1'b0;
        exp_req_valid = 1'b0; chk_req = 1'b0; exp_stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678; exp_ld = 32'h0;
        check("rr_state", 32'(debug_state), 32'd0);
        check("rr_load_data", LoadData, 32'h0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        idle_cycle();
        check("rr_no_load_valid", 32'(lv_cnt), 32'd0);
        run_op(1'b0, 1'b1, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);
        check("rr_next_lw", LoadData, 32'hCAFEF00D);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(kind != 0, kind != 1, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        check("load_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that consumes the decode controls `MemWrite`, `MemtoReg` and `LoadOrStoreTYPE`, together with the ALU-computed address and the rs2 store data. It performs one byte, halfword or word access per instruction over a valid/ready data-memory port. It does the lane steering, write-strobe generation, load sign/zero extension and alignment checking. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `XLEN`, 32: address and data width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `op_valid`  in  1  instruction present in this stage.
- `MemWrite`  in  1  store.
- `MemtoReg`  in  1  load.
- `LoadOrStoreTYPE`  in  3  funct3 width/sign code.
- `Address`  in  XLEN  byte address (ALU result).
- `StoreData`  in  XLEN  rs2 value.
- `Stall`  out  1  freeze the upstream stages and hold the inputs stable.
- `LoadData`  out  XLEN  extended load result.
- `LoadValid`  out  1  one-cycle pulse when `LoadData` is updated.
- `Fault`  out  1  one-cycle pulse on a misaligned or illegal access.
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  XLEN  word address, with `[1:0]` = 0.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_wstrb`  out  4  byte write enables.
- `mem_rsp_valid`  in  1  read data or write acknowledge.
- `mem_rdata`  in  XLEN  read word.

## Operation
- **Start condition:** start = `op_valid & (MemWrite | MemtoReg)`.
  - If both `MemWrite` and `MemtoReg` are set, the access is a store.
  - With no start, the block is transparent: `Stall` = 0 and no request is issued.
- **Legal funct3 encodings:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other encoding is illegal.
- **Misalignment:** H requires `Address[0]`=0; W requires `Address[1:0]`=0.
- **Capture on accept (in IDLE):** we, funct3, `Address[1:0]`, the word address, the wdata and the wstrb are registered.
- **Write strobes (o = `Address[1:0]`):**
  - SB: `4'b0001<<o`.
  - SH: `4'b0011<<o`.
  - SW: `4'b1111`.
  - Loads: `4'b0000`.
- **Write data:** SB = `{4{StoreData[7:0]}}`; SH = `{2{StoreData[15:0]}}`; SW = `StoreData`.
- **Load data:**
  - Lane = `mem_rdata >> (8*o)`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - LW returns the word unchanged.
- **FSM states:** IDLE, REQ, RESP, DONE.
  - IDLE, start and legal → REQ.
  - IDLE, start and fault → DONE with `Fault` set; no memory request is issued.
  - REQ: `mem_req_valid`=1, with all request fields stable. On `mem_req_ready` → RESP.
  - RESP: wait for `mem_rsp_valid`. On it, register the extracted load data (loads only) → DONE.
  - DONE: pulse `LoadValid` (loads) or `Fault` (faults) for one cycle → IDLE. Start is ignored in DONE because the inputs still show the finished op.
- **Response filtering:** `mem_rsp_valid` is ignored outside RESP.
- **Stores:** they complete on their acknowledge. `LoadData` is unchanged and `LoadValid` stays 0.

## Timing
- **Reset values:** state IDLE; `mem_req_valid`, `mem_we`, `LoadValid`, `Fault` = 0; `mem_addr`, `mem_wdata`, `LoadData` = 0; `mem_wstrb` = 0.
- **`Stall`:**
  - Combinational: `(IDLE & start) | REQ | RESP`.
  - Forced to 0 while `rst_n`=0.
  - 0 in DONE; the pipeline advances at the end of DONE.
- **Minimum access:** 4 cycles (IDLE accept, REQ accepted, RESP with response, DONE).
  - Each cycle of `mem_req_ready`=0 adds one cycle in REQ.
  - Each cycle without `mem_rsp_valid` adds one cycle in RESP.
- **Fault path:** 2 cycles (IDLE, then DONE).
- **Response timing:** memory responds no earlier than the cycle after acceptance; there is never more than one outstanding request.
- **`LoadData`:** holds its value until the next completed load.
- **Reset mid-operation:** next edge → IDLE with `mem_req_valid` low. A late response from the aborted access is ignored.

## Test plan
- **LW aligned:** `Address`=0x100, `mem_rdata`=0xDEADBEEF, ready and response immediate → `mem_addr`=0x100, `mem_wstrb`=0, `LoadData`=0xDEADBEEF, `LoadValid` in cycle 3, `Stall` high in cycles 0-2.
- **LB and LBU:** `Address`=0x203, `mem_rdata`=0x80123456.
  - LB → `LoadData`=0xFFFFFF80.
  - LBU → `LoadData`=0x00000080.
- **SH:** `Address`=0x302, `StoreData`=0x1234ABCD → `mem_addr`=0x300, `mem_wstrb`=0b1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `LoadValid` stays 0.
- **Fault cases:**
  - LW at 0x102 → `Fault` pulse in cycle 1, no `mem_req_valid`, `Stall` high for 1 cycle.
  - funct3=011 with `MemtoReg` → same response.
- **Backpressure:** `mem_req_ready` low for 3 cycles, then the response 2 cycles after acceptance → request fields stable throughout, `Stall` high for 7 cycles, single completion.
- **Reset in RESP:** `rst_n` low for 1 cycle, then `mem_rsp_valid` → no `LoadValid`, `LoadData`=0, state IDLE, next LW completes normally.
